// File: rtl/singlecycle_pkg.sv
// Shared types and constants for the single-cycle CPU: ISA encodings, ALU ops,
// decoded control word, plus the fixed program ROM and the data RAM seed.
package singlecycle_pkg;

  typedef logic [31:0] word_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_t;

  // One decoded instruction; all-zero means "do nothing but advance PC".
  typedef struct packed {
    logic    reg_we;
    logic    dst_rd;   // 1: write rd (R-type), 0: write rt (I-type)
    logic    src_imm;  // ALU operand B from sign-extended immediate
    logic    mem_rd;   // writeback from data RAM
    logic    mem_we;
    logic    beq;
    logic    bne;
    logic    jump;
    alu_op_t alu_op;
  } ctrl_t;

  function automatic word_t enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                  input logic [4:0] rd, input logic [5:0] fn);
    return {OP_RTYPE, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic word_t enc_i(input logic [5:0] op, input logic [4:0] rs,
                                  input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Running signed maximum of dmem words 0..7 into r7, then store it at word 8.
  function automatic word_t rom_word(input int idx);
    case (idx)
      0:       return enc_i(OP_ADDI, 5'd0, 5'd1, 16'd0);
      1:       return enc_i(OP_ADDI, 5'd0, 5'd2, 16'd32);
      2:       return enc_i(OP_ADDI, 5'd0, 5'd7, 16'd0);
      3:       return enc_i(OP_LW,   5'd1, 5'd3, 16'd0);
      4:       return enc_r(5'd7, 5'd3, 5'd4, FN_SLT);
      5:       return enc_i(OP_BEQ,  5'd4, 5'd0, 16'd1);
      6:       return enc_r(5'd3, 5'd0, 5'd7, FN_ADD);
      7:       return enc_i(OP_ADDI, 5'd1, 5'd1, 16'd4);
      8:       return enc_i(OP_BNE,  5'd1, 5'd2, 16'hFFFA);
      9:       return enc_i(OP_SW,   5'd0, 5'd7, 16'd32);
      10:      return {OP_J, 26'd10};
      default: return '0;
    endcase
  endfunction

  function automatic word_t dmem_seed(input int idx);
    case (idx)
      0:       return 32'd5;
      1:       return 32'd23;
      2:       return 32'd7;
      3:       return 32'd42;
      4:       return 32'd19;
      5:       return 32'd3;
      6:       return 32'd41;
      7:       return 32'd12;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/singlecycle_alu.sv
// 32-bit ALU: wrapping add/sub, bitwise and/or, signed set-less-than.
module singlecycle_alu
  import singlecycle_pkg::*;
(
  input  word_t   a,
  input  word_t   b,
  input  alu_op_t op,
  output word_t   result,
  output logic    zero
);

  // Pure combinational operation select; overflow is simply dropped.
  always_comb begin
    result = '0;
    case (op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLT: result = {31'd0, $signed(a) < $signed(b)};
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/singlecycle.sv
// Single-cycle 32-bit RISC core running a fixed max-finding program from ROM.
module singlecycle
  import singlecycle_pkg::*;
#(
  parameter int IMEM_WORDS = 64,
  parameter int DMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] max
);

  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_WORDS);

  typedef word_t dmem_t [DMEM_WORDS];

  function automatic dmem_t dmem_init();
    dmem_t m;
    for (int i = 0; i < DMEM_WORDS; i++) m[i] = dmem_seed(i);
    return m;
  endfunction

  word_t              pc, pc4, pc_nxt, instr, imm_ext;
  word_t              rs_val, rt_val, alu_b, alu_res, rdata, wb_val;
  logic [31:0][31:0]  rf;
  // Power-up contents; reset deliberately leaves data RAM alone.
  dmem_t              dmem = dmem_init();
  ctrl_t              ctrl;
  logic               alu_zero, taken;
  logic [5:0]         opcode, funct;
  logic [4:0]         rs, rt, rd, waddr;
  logic [IAW-1:0]     iidx;
  logic [DAW-1:0]     didx;
  logic               unused_bits;

  assign iidx    = pc[IAW+1:2];
  assign instr   = rom_word(int'(iidx));
  assign opcode  = instr[31:26];
  assign rs      = instr[25:21];
  assign rt      = instr[20:16];
  assign rd      = instr[15:11];
  assign funct   = instr[5:0];
  assign imm_ext = {{16{instr[15]}}, instr[15:0]};

  // Control decode; undefined opcode/funct leaves everything deasserted.
  always_comb begin
    ctrl        = '0;
    ctrl.alu_op = ALU_ADD;
    case (opcode)
      OP_RTYPE: begin
        ctrl.dst_rd = 1'b1;
        ctrl.reg_we = 1'b1;
        case (funct)
          FN_ADD:  ctrl.alu_op = ALU_ADD;
          FN_SUB:  ctrl.alu_op = ALU_SUB;
          FN_AND:  ctrl.alu_op = ALU_AND;
          FN_OR:   ctrl.alu_op = ALU_OR;
          FN_SLT:  ctrl.alu_op = ALU_SLT;
          default: ctrl.reg_we = 1'b0;
        endcase
      end
      OP_ADDI: begin
        ctrl.reg_we  = 1'b1;
        ctrl.src_imm = 1'b1;
      end
      OP_LW: begin
        ctrl.reg_we  = 1'b1;
        ctrl.src_imm = 1'b1;
        ctrl.mem_rd  = 1'b1;
      end
      OP_SW: begin
        ctrl.src_imm = 1'b1;
        ctrl.mem_we  = 1'b1;
      end
      OP_BEQ: begin
        ctrl.beq    = 1'b1;
        ctrl.alu_op = ALU_SUB;
      end
      OP_BNE: begin
        ctrl.bne    = 1'b1;
        ctrl.alu_op = ALU_SUB;
      end
      OP_J:    ctrl.jump = 1'b1;
      default: ;
    endcase
  end

  // r0 is forced to zero on read, so its storage never matters.
  assign rs_val = (rs == 5'd0) ? '0 : rf[rs];
  assign rt_val = (rt == 5'd0) ? '0 : rf[rt];
  assign alu_b  = ctrl.src_imm ? imm_ext : rt_val;

  singlecycle_alu u_alu (
    .a      (rs_val),
    .b      (alu_b),
    .op     (ctrl.alu_op),
    .result (alu_res),
    .zero   (alu_zero)
  );

  assign didx   = alu_res[DAW+1:2];
  assign rdata  = dmem[didx];
  assign wb_val = ctrl.mem_rd ? rdata : alu_res;
  assign waddr  = ctrl.dst_rd ? rd : rt;

  assign pc4    = pc + 32'd4;
  assign taken  = (ctrl.beq & alu_zero) | (ctrl.bne & ~alu_zero);
  assign pc_nxt = ctrl.jump ? {pc4[31:28], instr[25:0], 2'b00} :
                  taken     ? pc4 + {imm_ext[29:0], 2'b00} : pc4;

  // Program counter, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc <= '0;
    else      pc <= pc_nxt;
  end

  // Register file write port; writes to r0 are dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                               rf        <= '0;
    else if (ctrl.reg_we && waddr != 5'd0)  rf[waddr] <= wb_val;
  end

  // Data RAM write port; not touched by reset.
  always_ff @(posedge clk) begin
    if (ctrl.mem_we) dmem[didx] <= rt_val;
  end

  assign max = rf[7][15:0];

  assign unused_bits = ^{instr[10:6], alu_res[31:DAW+2], alu_res[1:0]};

endmodule

// File: tb/tb_singlecycle.sv
// Bench for singlecycle: reset behaviour, the ROM program on seeded, preloaded
// and random data against a signed-max model, and ALU unit checks.
module tb_singlecycle;
  import singlecycle_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] max;
  int          checks = 0;
  int          failures = 0;

  word_t   ta, tbv, tres;
  alu_op_t top;
  logic    tzero;

  word_t data [8];

  singlecycle #(.IMEM_WORDS(64), .DMEM_WORDS(64)) dut (
    .clk (clk),
    .rst (rst),
    .max (max)
  );

  singlecycle_alu u_alu (
    .a      (ta),
    .b      (tbv),
    .op     (top),
    .result (tres),
    .zero   (tzero)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Program result: r7 starts at 0 and takes any word that is signed-greater.
  function automatic word_t prog_max();
    int m = 0;
    for (int i = 0; i < 8; i++)
      if (int'(data[i]) > m) m = int'(data[i]);
    return word_t'(m);
  endfunction

  function automatic word_t alu_ref(input alu_op_t op, input word_t a, input word_t b);
    case (op)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_SLT: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic load_and_run(input string tag);
    word_t expv;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) dut.dmem[i] = data[i];
    check({tag, "_rstmax"}, {16'd0, max}, 32'd0);
    rst = 1'b1;
    cycles(60);
    expv = prog_max();
    check({tag, "_max"}, {16'd0, max}, {16'd0, expv[15:0]});
    check({tag, "_dmem8"}, dut.dmem[8], expv);
    check({tag, "_pc"}, dut.pc, 32'd40);
  endtask

  initial begin
    // Reset held for 35 ns across clock edges
    #5  check("rst_max_t5",  {16'd0, max}, 32'd0);
    check("rst_pc_t5", dut.pc, 32'd0);
    #10 check("rst_max_t15", {16'd0, max}, 32'd0);
    #10 check("rst_max_t25", {16'd0, max}, 32'd0);
    check("rst_pc_t25", dut.pc, 32'd0);
    #10 rst = 1'b1;

    // First edge after release executes word 0
    cycles(1);
    check("first_pc", dut.pc, 32'd4);
    cycles(59);
    for (int i = 0; i < 8; i++) data[i] = dmem_seed(i);
    check("seed_model", {16'd0, max}, {16'd0, prog_max() & 32'hFFFF});
    check("seed_max42", {16'd0, max}, 32'd42);
    check("seed_dmem8", dut.dmem[8], 32'd42);

    // Spin at word 10
    for (int k = 0; k < 10; k++) begin
      cycles(10);
      check("spin_max", {16'd0, max}, 32'd42);
      check("spin_pc", dut.pc, 32'd40);
    end

    // Asynchronous reset clears PC/registers, keeps RAM
    rst = 1'b0;
    #1;
    check("async_max", {16'd0, max}, 32'd0);
    check("async_pc", dut.pc, 32'd0);
    check("async_ram", dut.dmem[8], 32'd42);
    #5 rst = 1'b1;
    cycles(20);
    rst = 1'b0;
    #1;
    check("mid_rst_max", {16'd0, max}, 32'd0);
    check("mid_rst_pc", dut.pc, 32'd0);
    cycles(1);
    check("mid_rst_hold_max", {16'd0, max}, 32'd0);
    check("mid_rst_hold_pc", dut.pc, 32'd0);
    rst = 1'b1;
    cycles(60);
    check("mid_rerun_max", {16'd0, max}, 32'd42);
    check("mid_rerun_dmem8", dut.dmem[8], 32'd42);

    // Negative words plus one wide positive: signed SLT and truncation
    for (int i = 0; i < 8; i++) data[i] = 32'hFFFF_FFFF;
    data[5] = 32'h0001_ABCD;
    load_and_run("preload");
    check("preload_abcd", {16'd0, max}, 32'h0000_ABCD);

    // All negative: r7 never moves off 0
    for (int i = 0; i < 8; i++) data[i] = 32'h8000_0000 | $urandom;
    load_and_run("allneg");

    // Random data sets
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 8; i++)
        data[i] = ($urandom_range(1, 0) == 1) ? $urandom : $urandom_range(70000, 0);
      load_and_run($sformatf("rand%0d", r));
    end

    // ALU unit checks
    top = ALU_SUB; ta = 32'd5; tbv = 32'd5; #1;
    check("alu_sub_res", tres, 32'd0);
    check("alu_sub_zero", {31'd0, tzero}, 32'd1);
    top = ALU_SLT; ta = 32'hFFFF_FFFF; tbv = 32'd1; #1;
    check("alu_slt", tres, 32'd1);
    top = ALU_ADD; ta = 32'h7FFF_FFFF; tbv = 32'd1; #1;
    check("alu_add_wrap", tres, 32'h8000_0000);
    check("alu_add_zero", {31'd0, tzero}, 32'd0);
    for (int k = 0; k < 30; k++) begin
      top = alu_op_t'($urandom_range(4, 0));
      ta  = $urandom;
      tbv = ($urandom_range(3, 0) == 0) ? ta : $urandom;
      #1;
      check($sformatf("alu_rand%0d_res", k), tres, alu_ref(top, ta, tbv));
      check($sformatf("alu_rand%0d_zero", k), {31'd0, tzero},
            {31'd0, alu_ref(top, ta, tbv) == 32'd0});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/singlecycle.md
SINGLECYCLE -- requirements
Module: singlecycle

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports are named as the codebase names them.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst  input  1  asynchronous active-low reset (0 = reset asserted, 1 = run).
REQ-004 Port: max  output  16  combinational copy of register r7[15:0]; this is the program's running/final maximum.
REQ-005 Parameter: IMEM_WORDS, default 64, instruction-ROM depth in 32-bit words.
REQ-006 Parameter: DMEM_WORDS, default 64, data-RAM depth in 32-bit words.

Function
REQ-007 The block SHALL be a 32-bit single-cycle RISC CPU: fetch, decode, execute, memory access and writeback all complete in one clk period.
REQ-008 Encoding: opcode[31:26], rs[25:21], rt[20:16], rd[15:11], funct[5:0], imm[15:0] sign-extended to 32 bits, jtarget[25:0].
REQ-009 R-type (opcode 000000), rd <= rs op rt, by funct: ADD 100000, SUB 100010, AND 100100, OR 100101, SLT 101010 (signed compare, result 1 or 0).
REQ-010 I-type: ADDI 001000 (rt <= rs+imm); LW 100011 (rt <= dmem[rs+imm]); SW 101011 (dmem[rs+imm] <= rt); BEQ 000100; BNE 000101.
REQ-011 J 000010: PC <= {PC+4[31:28], jtarget, 2'b00}.
REQ-012 Branch taken: PC <= PC+4 + (imm<<2); otherwise, and for all other non-jump instructions, PC <= PC+4.
REQ-013 Undefined opcode or funct: no register or memory write; PC <= PC+4.
REQ-014 Arithmetic is 32-bit two's-complement, wrapping; overflow is ignored and raises no exception.
REQ-015 Register file: 32 x 32-bit, two combinational read ports, one write port written on rising clk; r0 always reads 0 and writes to it are discarded.
REQ-016 PC is a byte address; the instruction ROM is indexed by PC[7:2] and data RAM by address[7:2]; higher address bits are ignored, so addresses wrap modulo memory size.
REQ-017 Data RAM: combinational read, synchronous write on rising clk when SW executes.
REQ-018 ROM contents (word: instruction): 0 ADDI r1,r0,0; 1 ADDI r2,r0,32; 2 ADDI r7,r0,0; 3 LW r3,0(r1); 4 SLT r4,r7,r3; 5 BEQ r4,r0,+1; 6 ADD r7,r3,r0; 7 ADDI r1,r1,4; 8 BNE r1,r2,-6; 9 SW r7,32(r0); 10 J 10; remaining words 0 (NOP).
REQ-019 Data RAM initial contents, words 0..7: 5, 23, 7, 42, 19, 3, 41, 12; all other words 0.
REQ-020 After the program completes, the CPU SHALL spin at word 10 indefinitely, with max stable.

Reset
REQ-021 While rst=0, PC SHALL be 0 and all 32 registers SHALL be 0, so max=0, independent of clk.
REQ-022 Reset asserted mid-program SHALL immediately clear PC and registers; data RAM SHALL keep its current contents.
REQ-023 Data RAM and ROM initial values SHALL be established at power-up or configuration, not by reset.
REQ-024 The first instruction (word 0) SHALL execute on the first rising clk edge after rst rises.

Structure
REQ-025 A shared package SHALL hold the opcode and funct constants, the ALU-operation enum and the 32-bit word typedef.
REQ-026 The ALU SHALL be a sub-module named singlecycle_alu, taking two 32-bit operands and an op, and producing a result and a zero flag.
REQ-027 The following SHALL remain in singlecycle: PC, control decoder, register file, ROM, data RAM and next-PC logic.

Verification
REQ-028 Hold rst=0 for 35 ns with a 20 ns clk, then release: max=0 throughout reset.
REQ-029 Run 60 cycles after reset release: max=42 (0x002A), and data RAM word 8 equals 42.
REQ-030 Continue 100 more cycles: max stays 42 and PC stays at byte address 40.
REQ-031 Assert rst=0 at cycle 20 for one cycle, then run 60 cycles: max returns to 0 during reset and ends at 42.
REQ-032 Preload data RAM words 0..7 with 0xFFFFFFFF (-1) except word 5 = 0x0001ABCD, then run: max=0xABCD, which checks signed SLT and 16-bit truncation.
REQ-033 Unit-test singlecycle_alu:
- SUB 5-5 -> result 0, zero=1
- SLT -1,1 -> 1
- ADD 0x7FFFFFFF+1 -> 0x80000000
